alu10_core: RTL and testbench

- 10-bit, 4-function ALU for the 10-bit CPU datapath.
- Operations: add with carry, subtract with borrow, signed-amount logical shift, bitwise NOR.
- Built from a 10-bit ripple adder, a 10-bit subtractor, a barrel shifter and a 4:1 10-bit result mux.
- Result and flags are registered once on the CPU clock before going to the register-file write-back path.

---
 rtl/alu10_core.sv | 138 +++++++++++++
 tb/tb_alu10_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu10_core.sv
// Registered 10-bit ALU: add with carry, subtract with borrow, signed-amount logical shift, NOR.
// Optional registered zero flag is enabled by defining ALU10_ZERO_FLAG_EN.
`timescale 1ns/1ps
module alu10_core #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [1:0]       opcode,
  input  logic             cin,
  input  logic             bin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             bout
`ifdef ALU10_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHF = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Ripple-carry adder
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_add
    assign sum[i]     = rs[i] ^ rt[i] ^ carry[i];
    assign carry[i+1] = (rs[i] & rt[i]) | (carry[i] & (rs[i] ^ rt[i]));
  end

  // Ripple-borrow subtractor; the final borrow is set exactly when rs < rt + bin
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    assign diff[i]  = rs[i] ^ rt[i] ^ brw[i];
    assign brw[i+1] = (~rs[i] & rt[i]) | (~(rs[i] ^ rt[i]) & brw[i]);
  end

  // Barrel shifter. Negative rt shifts right by its magnitude; any magnitude
  // of WIDTH or more (including the most negative value) clears the result.
  logic [WIDTH-1:0] amt_mag;
  logic             amt_neg;
  logic             amt_oor;
  logic [WIDTH-1:0] lsh [0:SHW];
  logic [WIDTH-1:0] rsh [0:SHW];
  logic [WIDTH-1:0] shift_res;

  assign amt_neg = rt[WIDTH-1];
  assign amt_mag = amt_neg ? -rt : rt;
  assign amt_oor = (amt_mag >= WIDTH'(WIDTH));

  assign lsh[0] = rs;
  assign rsh[0] = rs;

  for (genvar s = 0; s < SHW; s++) begin : g_shf
    assign lsh[s+1] = amt_mag[s] ? (lsh[s] << (2 ** s)) : lsh[s];
    assign rsh[s+1] = amt_mag[s] ? (rsh[s] >> (2 ** s)) : rsh[s];
  end

  always_comb begin
    shift_res = '0;
    if (!amt_oor) begin
      shift_res = amt_neg ? rsh[SHW] : lsh[SHW];
    end
  end

  // Result mux and next-state values
  logic [WIDTH-1:0] result_d;
  logic             cout_d;
  logic             bout_d;

  always_comb begin
    result_d = '0;
    case (opcode)
      OP_ADD:  result_d = sum;
      OP_SUB:  result_d = diff;
      OP_SHF:  result_d = shift_res;
      OP_NOR:  result_d = ~(rs | rt);
      default: result_d = '0;
    endcase
  end

  // Both flags are captured every cycle whatever the opcode
  assign cout_d = carry[WIDTH];
  assign bout_d = brw[WIDTH];

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             bout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      bout_q   <= bout_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign bout   = bout_q;

`ifdef ALU10_ZERO_FLAG_EN
  logic zero_d;
  logic zero_q;

  assign zero_d = (result_d == '0);

  // Resets to 1 so it agrees with the cleared result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu10_core.sv
// Directed-vector bench for alu10_core: arithmetic reference model, expected queue,
// per-cycle compare process, and literal expectations that pin the model.
`timescale 1ns/1ps
module tb_alu10_core;

  localparam int W = 10;

  logic         clk;
  logic         reset;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic [1:0]   opcode;
  logic         cin;
  logic         bin;
  logic [W-1:0] result;
  logic         cout;
  logic         bout;
`ifdef ALU10_ZERO_FLAG_EN
  logic         zero;
`endif

  alu10_core #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .rs     (rs),
    .rt     (rt),
    .opcode (opcode),
    .cin    (cin),
    .bin    (bin),
    .result (result),
    .cout   (cout),
    .bout   (bout)
`ifdef ALU10_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  // packed as {zero, bout, cout, result}
  logic [W+2:0] exp_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         bi;
    logic [W-1:0] er;   // hand-computed result
    logic         ef;   // hand-computed cout (add) or bout (sub)
  } vec_t;

  vec_t vt[20];

  // Reference model written from the arithmetic definitions
  function automatic logic [W+2:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic ci,
                                         input logic bi);
    int s, d, amt, r;
    logic co, bo, z;
    s  = int'(a) + int'(b) + int'(ci);
    co = (s >= 1024);
    d  = int'(a) - int'(b) - int'(bi);
    bo = (int'(a) < int'(b) + int'(bi));
    amt = (int'(b) >= 512) ? int'(b) - 1024 : int'(b);
    case (op)
      2'b00: r = s % 1024;
      2'b01: r = (d + 2048) % 1024;
      2'b10: begin
        if (amt == 0)                   r = int'(a);
        else if (amt >= 1 && amt <= 9)  r = (int'(a) * (1 << amt)) % 1024;
        else if (amt <= -1 && amt >= -9) r = int'(a) / (1 << (-amt));
        else                            r = 0;
      end
      default: r = 1023 - (int'(a | b));
    endcase
    z = (r == 0);
    return {z, bo, co, W'(r)};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [W+2:0] e;
    #1;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("result", int'(result), int'(e[W-1:0]));
      check("cout", int'(cout), int'(e[W]));
      check("bout", int'(bout), int'(e[W+1]));
`ifdef ALU10_ZERO_FLAG_EN
      check("zero", int'(zero), int'(e[W+2]));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    logic [W+2:0] m;
    @(negedge clk);
    opcode = v.op;
    rs     = v.a;
    rt     = v.b;
    cin    = v.ci;
    bin    = v.bi;
    m = model(v.op, v.a, v.b, v.ci, v.bi);
    check("model_result_literal", int'(m[W-1:0]), int'(v.er));
    if (v.op == 2'b00) check("model_cout_literal", int'(m[W]), int'(v.ef));
    if (v.op == 2'b01) check("model_bout_literal", int'(m[W+1]), int'(v.ef));
    exp_q.push_back(m);
  endtask

  initial begin
    //          op     rs              rt              ci    bi    result          flag
    vt[0]  = '{2'b00, 10'd3,          10'd5,          1'b0, 1'b0, 10'd8,          1'b0};
    vt[1]  = '{2'b00, 10'd1023,       10'd1,          1'b0, 1'b0, 10'd0,          1'b1};
    vt[2]  = '{2'b00, 10'd3,          10'd5,          1'b1, 1'b0, 10'd9,          1'b0};
    vt[3]  = '{2'b01, 10'd10,         10'd3,          1'b0, 1'b0, 10'd7,          1'b0};
    vt[4]  = '{2'b01, 10'd0,          10'd1,          1'b0, 1'b0, 10'd1023,       1'b1};
    vt[5]  = '{2'b01, 10'd5,          10'd5,          1'b0, 1'b1, 10'd1023,       1'b1};
    vt[6]  = '{2'b10, 10'd2,          10'd1,          1'b0, 1'b0, 10'd4,          1'b0};
    vt[7]  = '{2'b10, 10'd2,          10'b1111111111, 1'b0, 1'b0, 10'd1,          1'b0};
    vt[8]  = '{2'b10, 10'd2,          10'd0,          1'b0, 1'b0, 10'd2,          1'b0};
    vt[9]  = '{2'b10, 10'b1000000001, 10'd9,          1'b0, 1'b0, 10'b1000000000, 1'b0};
    vt[10] = '{2'b10, 10'b1000000001, 10'd1015,       1'b0, 1'b0, 10'd1,          1'b0};
    vt[11] = '{2'b10, 10'b1000000001, 10'd10,         1'b0, 1'b0, 10'd0,          1'b0};
    vt[12] = '{2'b10, 10'b1000000001, 10'd1014,       1'b0, 1'b0, 10'd0,          1'b0};
    vt[13] = '{2'b10, 10'b1000000001, 10'd512,        1'b0, 1'b0, 10'd0,          1'b0};
    vt[14] = '{2'b11, 10'b1111111100, 10'b0011101100, 1'b0, 1'b0, 10'b0000000011, 1'b0};
    vt[15] = '{2'b11, 10'd0,          10'd0,          1'b0, 1'b0, 10'd1023,       1'b0};
    vt[16] = '{2'b11, 10'd1023,       10'd0,          1'b0, 1'b0, 10'd0,          1'b0};
    vt[17] = '{2'b10, 10'd1023,       10'd5,          1'b0, 1'b0, 10'b1111100000, 1'b0};
    vt[18] = '{2'b10, 10'd1023,       10'd1019,       1'b0, 1'b0, 10'd31,         1'b0};
    vt[19] = '{2'b00, 10'd512,        10'd511,        1'b1, 1'b0, 10'd0,          1'b1};

    reset  = 1'b0;
    rs     = 10'd3;
    rt     = 10'd5;
    opcode = 2'b00;
    cin    = 1'b0;
    bin    = 1'b0;

    // Asynchronous reset between edges, then held across edges with live inputs
    #2 reset = 1'b1;
    #1;
    check("reset_async_result", int'(result), 0);
    check("reset_async_cout", int'(cout), 0);
    check("reset_async_bout", int'(bout), 0);
`ifdef ALU10_ZERO_FLAG_EN
    check("reset_async_zero", int'(zero), 1);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold_result", int'(result), 0);
    reset = 1'b0;

    // First block of back-to-back operations, ending on a nonzero result
    for (int i = 0; i < 16; i++) drive(vt[i]);
    @(posedge clk);
    #3;
    check("pre_reset_nonzero", int'(result != '0), 1);

    // Mid-stream reset clears outputs without an edge and drops the pending capture
    reset = 1'b1;
    #1;
    check("midreset_result", int'(result), 0);
    check("midreset_cout", int'(cout), 0);
    check("midreset_bout", int'(bout), 0);
    exp_q.delete();
    rs = 10'd3; rt = 10'd5; opcode = 2'b00; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_hold_result", int'(result), 0);
    reset = 1'b0;

    for (int i = 16; i < 20; i++) drive(vt[i]);
    // Re-run the first vector after reset to cover add following shifts
    drive(vt[0]);
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout got=%0t expected=<20000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
